uart_operand_packer: RTL and testbench

Parametrised byte-to-operand assembler between the UART receiver and the floating-point datapath. Gathers a frame of NUM_OPERAND words, each SIZE_DATA_O bits wide, from a stream of SIZE_DATA_I-bit received bytes. Presents the frame on a valid/ready interface and raises a per-operand completion pulse. Adds inter-byte timeout resynchronisation, selectable byte order, flush and overflow reporting.

---
 rtl/uart_operand_packer.sv | 242 ++++++++++++++++++++++++
 tb/tb_uart_operand_packer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_operand_packer.sv
// -----------------------------------------------------------------------------
// uart_operand_packer
//
// Assembles a frame of NUM_OPERAND words, each SIZE_DATA_O bits wide, from a
// stream of SIZE_DATA_I-bit bytes delivered by the UART receiver. The completed
// frame is presented on a valid/ready interface towards the floating-point
// datapath. A completion pulse is raised per operand. Also provides an
// inter-byte timeout that resynchronises a stalled partial frame, a selectable
// byte order, a flush input and overflow reporting.
//
// Ports:
//   i_clk          sole clock, rising edge
//   i_rst          synchronous, active-high reset
//   i_wr_en        byte strobe, one cycle per received byte
//   i_fifo_data    received byte, sampled when i_wr_en=1
//   i_flush        discard the partial frame and the held frame
//   i_ready        downstream accepts the held frame
//   o_valid        frame held on o_data (state HOLD)
//   o_data         operand k at [k*SIZE_DATA_O +: SIZE_DATA_O]
//   o_done         bit k pulses one cycle when operand k completes
//   o_busy         partial frame in progress (state COLLECT)
//   o_err_timeout  pulse: partial frame discarded after an idle gap
//   o_err_overflow pulse: byte dropped because a frame is held
// -----------------------------------------------------------------------------
module uart_operand_packer #(
   parameter int unsigned SIZE_DATA_I    = 8,
   parameter int unsigned SIZE_DATA_O    = 32,
   parameter int unsigned NUM_OPERAND    = 2,
   parameter bit          MSB_FIRST      = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic                                i_clk,
   input  logic                                i_rst,
   input  logic                                i_wr_en,
   input  logic [SIZE_DATA_I-1:0]              i_fifo_data,
   input  logic                                i_flush,
   input  logic                                i_ready,
   output logic                                o_valid,
   output logic [NUM_OPERAND*SIZE_DATA_O-1:0]  o_data,
   output logic [NUM_OPERAND-1:0]              o_done,
   output logic                                o_busy,
   output logic                                o_err_timeout,
   output logic                                o_err_overflow
);

   localparam int unsigned BPW        = SIZE_DATA_O / SIZE_DATA_I;
   localparam int unsigned FRAME_W    = NUM_OPERAND * SIZE_DATA_O;
   localparam int unsigned BIDX_W     = (BPW > 1) ? $clog2(BPW) : 1;
   localparam int unsigned OIDX_W     = (NUM_OPERAND > 1) ? $clog2(NUM_OPERAND) : 1;
   localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
   localparam int unsigned CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(BPW - 1);
   localparam logic [OIDX_W-1:0] OIDX_LAST = OIDX_W'(NUM_OPERAND - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {StIdle, StCollect, StHold} state_e;

   state_e              state_q, state_d;
   logic [FRAME_W-1:0]  coll_q, coll_d;
   logic [FRAME_W-1:0]  coll_wr;
   logic [BIDX_W-1:0]   bidx_q, bidx_d;
   logic [OIDX_W-1:0]   oidx_q, oidx_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [FRAME_W-1:0]  data_q, data_d;
   logic [NUM_OPERAND-1:0] done_q, done_d;
   logic                err_to_q, err_to_d;
   logic                err_ov_q, err_ov_d;

   // Decoded events for the current cycle
   logic take;          // byte accepted into the collect buffer
   logic last_byte;     // current byte position is the last of its operand
   logic frame_end;     // accepted byte completes the frame
   logic timeout_hit;   // idle gap expired inside a partial frame
   logic overflow;      // byte arrives while a frame is held and not consumed

   // ---------------------------------------------------------------------------
   // Event decode. Flush masks every event, including the coincident byte.
   // Indices are always zero outside COLLECT, so a byte taken in IDLE or on the
   // handshake cycle of HOLD lands at byte 0 of operand 0.
   // ---------------------------------------------------------------------------
   always_comb begin
      take        = 1'b0;
      timeout_hit = 1'b0;
      overflow    = 1'b0;
      if (!i_flush) begin
         unique case (state_q)
            StIdle: begin
               take = i_wr_en;
            end
            StCollect: begin
               take        = i_wr_en;
               timeout_hit = TIMEOUT_EN && !i_wr_en && (cnt_q == CNT_LAST);
            end
            StHold: begin
               take     = i_wr_en && i_ready;
               overflow = i_wr_en && !i_ready;
            end
            default: ;
         endcase
      end
      last_byte = (bidx_q == BIDX_LAST);
      frame_end = take && last_byte && (oidx_q == OIDX_LAST);
   end

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      if (i_flush) begin
         state_d = StIdle;
      end else if (frame_end) begin
         state_d = StHold;
      end else if (take) begin
         state_d = StCollect;
      end else if (timeout_hit) begin
         state_d = StIdle;
      end else if (state_q == StHold && i_ready) begin
         state_d = StIdle;
      end else if (state_q != StIdle && state_q != StCollect && state_q != StHold) begin
         state_d = StIdle;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs. All driven from registers only.
   // ---------------------------------------------------------------------------
   always_comb begin
      o_valid        = (state_q == StHold);
      o_busy         = (state_q == StCollect);
      o_data         = data_q;
      o_done         = done_q;
      o_err_timeout  = err_to_q;
      o_err_overflow = err_ov_q;
   end

   // ---------------------------------------------------------------------------
   // Byte placement: the collect buffer with the incoming byte written at the
   // current operand/byte position, honouring the configured byte order.
   // ---------------------------------------------------------------------------
   always_comb begin
      coll_wr = coll_q;
      for (int k = 0; k < NUM_OPERAND; k++) begin
         for (int j = 0; j < BPW; j++) begin
            if (oidx_q == OIDX_W'(k) && bidx_q == BIDX_W'(j)) begin
               coll_wr[k*SIZE_DATA_O + (MSB_FIRST ? (BPW-1-j) : j)*SIZE_DATA_I +: SIZE_DATA_I]
                  = i_fifo_data;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Datapath next-state
   // ---------------------------------------------------------------------------
   always_comb begin
      coll_d   = coll_q;
      bidx_d   = bidx_q;
      oidx_d   = oidx_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      done_d   = '0;
      err_to_d = timeout_hit;
      err_ov_d = overflow;

      if (i_flush) begin
         // o_data deliberately keeps the last completed frame
         coll_d = '0;
         bidx_d = '0;
         oidx_d = '0;
         cnt_d  = '0;
      end else if (take) begin
         cnt_d = '0;
         if (frame_end) begin
            data_d = coll_wr;
            coll_d = '0;
            bidx_d = '0;
            oidx_d = '0;
         end else begin
            coll_d = coll_wr;
            if (last_byte) begin
               bidx_d = '0;
               oidx_d = oidx_q + OIDX_W'(1);
            end else begin
               bidx_d = bidx_q + BIDX_W'(1);
            end
         end
         for (int k = 0; k < NUM_OPERAND; k++) begin
            if (oidx_q == OIDX_W'(k)) begin
               done_d[k] = last_byte;
            end
         end
      end else if (timeout_hit) begin
         coll_d = '0;
         bidx_d = '0;
         oidx_d = '0;
         cnt_d  = '0;
      end else if (TIMEOUT_EN && state_q == StCollect) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (state_q != StCollect) begin
         cnt_d = '0;
      end
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         coll_q   <= '0;
         bidx_q   <= '0;
         oidx_q   <= '0;
         cnt_q    <= '0;
         data_q   <= '0;
         done_q   <= '0;
         err_to_q <= 1'b0;
         err_ov_q <= 1'b0;
      end else begin
         coll_q   <= coll_d;
         bidx_q   <= bidx_d;
         oidx_q   <= oidx_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         done_q   <= done_d;
         err_to_q <= err_to_d;
         err_ov_q <= err_ov_d;
      end
   end

endmodule

// File: tb/tb_uart_operand_packer.sv
// -----------------------------------------------------------------------------
// Testbench for uart_operand_packer. Four instances with different parameter
// sets share clock and reset; each has its own byte/flush/ready inputs.
//   0: defaults      1: MSB_FIRST=0      2: TIMEOUT_CYCLES=20
//   3: NUM_OPERAND=3, SIZE_DATA_O=16
// Expected frames are queued when stimulus is driven and compared when an
// instance raises o_valid.
// -----------------------------------------------------------------------------
module tb_uart_operand_packer;

   typedef struct packed {
      logic [1:0]  dut;
      logic [63:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  wr_en = '0;
   logic [3:0]  flush = '0;
   logic [3:0]  ready = '0;
   logic [7:0]  din [4];

   // Instances 0..2 (two 32-bit operands)
   logic [2:0]  valid2, busy2, eto2, eov2;
   logic [63:0] data2 [3];
   logic [1:0]  done2 [3];
   // Instance 3 (three 16-bit operands)
   logic        valid_d, busy_d, eto_d, eov_d;
   logic [47:0] data_d;
   logic [2:0]  done_d;

   logic [3:0]  vld_all, vld_prev;
   logic [63:0] dat_all [4];

   exp_t sb[$];
   exp_t mon_e;
   int   n_chk = 0;
   int   n_err = 0;
   int   n_frames = 0;

   always #5 clk = ~clk;

   uart_operand_packer u_dut0 (
      .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en[0]), .i_fifo_data(din[0]),
      .i_flush(flush[0]), .i_ready(ready[0]), .o_valid(valid2[0]), .o_data(data2[0]),
      .o_done(done2[0]), .o_busy(busy2[0]), .o_err_timeout(eto2[0]),
      .o_err_overflow(eov2[0])
   );

   uart_operand_packer #(.MSB_FIRST(1'b0)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en[1]), .i_fifo_data(din[1]),
      .i_flush(flush[1]), .i_ready(ready[1]), .o_valid(valid2[1]), .o_data(data2[1]),
      .o_done(done2[1]), .o_busy(busy2[1]), .o_err_timeout(eto2[1]),
      .o_err_overflow(eov2[1])
   );

   uart_operand_packer #(.TIMEOUT_CYCLES(20)) u_dut2 (
      .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en[2]), .i_fifo_data(din[2]),
      .i_flush(flush[2]), .i_ready(ready[2]), .o_valid(valid2[2]), .o_data(data2[2]),
      .o_done(done2[2]), .o_busy(busy2[2]), .o_err_timeout(eto2[2]),
      .o_err_overflow(eov2[2])
   );

   uart_operand_packer #(.NUM_OPERAND(3), .SIZE_DATA_O(16)) u_dut3 (
      .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en[3]), .i_fifo_data(din[3]),
      .i_flush(flush[3]), .i_ready(ready[3]), .o_valid(valid_d), .o_data(data_d),
      .o_done(done_d), .o_busy(busy_d), .o_err_timeout(eto_d),
      .o_err_overflow(eov_d)
   );

   always_comb begin
      vld_all    = {valid_d, valid2};
      dat_all[0] = data2[0];
      dat_all[1] = data2[1];
      dat_all[2] = data2[2];
      dat_all[3] = {16'h0000, data_d};
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Scoreboard monitor: a new frame is reported on the rising edge of o_valid
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (vld_all[i] && !vld_prev[i]) begin
            n_frames++;
            check_eq("sb_avail", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
               mon_e = sb.pop_front();
               check_eq("sb_dut", 64'(i), 64'(mon_e.dut));
               check_eq("sb_data", dat_all[i], mon_e.data);
            end
         end
      end
      vld_prev <= vld_all;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic send_byte(input int i, input logic [7:0] b);
      @(negedge clk);
      wr_en[i] = 1'b1;
      din[i]   = b;
      @(negedge clk);
      wr_en[i] = 1'b0;
   endtask

   // Sends bytes first..7 of an 8-byte frame (byte n at bytes[63-8n -: 8])
   // to a two-operand instance, checking the operand completion pulses.
   task automatic send_frame(input int i, input logic [63:0] bytes, input int gap,
                             input string tag, input int first);
      for (int n = first; n < 8; n++) begin
         send_byte(i, bytes[63-8*n -: 8]);
         check_eq({tag, "_done"}, 64'(done2[i]), (n == 3) ? 64'd1 : (n == 7) ? 64'd2 : 64'd0);
         if (n == 7) check_eq({tag, "_valid"}, 64'(valid2[i]), 64'd1);
         repeat (gap) @(negedge clk);
      end
   endtask

   initial begin
      int          n_pulse;
      int          at;
      logic [2:0]  e3;
      vld_prev = '0;
      for (int i = 0; i < 4; i++) din[i] = 8'h00;

      // Reset state
      repeat (3) @(negedge clk);
      check_eq("rst_valid", 64'(vld_all), 64'd0);
      check_eq("rst_busy", 64'({busy_d, busy2}), 64'd0);
      check_eq("rst_err", 64'({eto_d, eov_d, eto2, eov2}), 64'd0);
      check_eq("rst_done", 64'({done_d, done2[2], done2[1], done2[0]}), 64'd0);
      check_eq("rst_data0", data2[0], 64'd0);
      rst = 1'b0;

      // Defaults, 10-cycle gaps, frame held until ready
      sb.push_back('{dut: 2'd0, data: 64'hAABBCCDD_11223344});
      send_frame(0, 64'h11223344_AABBCCDD, 9, "t1", 0);
      check_eq("t1_hold", 64'(valid2[0]), 64'd1);
      @(negedge clk); ready[0] = 1'b1;
      @(negedge clk); ready[0] = 1'b0;
      check_eq("t1_consumed", 64'(valid2[0]), 64'd0);

      // LSB-first byte order
      ready[1] = 1'b1;
      sb.push_back('{dut: 2'd1, data: 64'hDDCCBBAA_44332211});
      send_frame(1, 64'h11223344_AABBCCDD, 0, "t2", 0);
      @(negedge clk);
      check_eq("t2_consumed", 64'(valid2[1]), 64'd0);

      // Timeout resynchronisation
      send_byte(2, 8'h11);
      send_byte(2, 8'h22);
      n_pulse = 0;
      at = -1;
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         if (eto2[2]) begin
            n_pulse++;
            at = k;
         end
      end
      check_eq("t3_pulses", 64'(n_pulse), 64'd1);
      check_eq("t3_when", 64'(at), 64'd20);
      check_eq("t3_busy", 64'(busy2[2]), 64'd0);
      ready[2] = 1'b1;
      sb.push_back('{dut: 2'd2, data: 64'h05060708_01020304});
      send_frame(2, 64'h01020304_05060708, 0, "t3", 0);

      // Overflow while held, then handshake coincident with a new byte
      sb.push_back('{dut: 2'd0, data: 64'h94959697_90919293});
      send_frame(0, 64'h90919293_94959697, 0, "t4a", 0);
      send_byte(0, 8'h99);
      check_eq("t4_overflow", 64'(eov2[0]), 64'd1);
      check_eq("t4_data_kept", data2[0], 64'h94959697_90919293);
      check_eq("t4_still_valid", 64'(valid2[0]), 64'd1);
      sb.push_back('{dut: 2'd0, data: 64'h12345678_55667788});
      @(negedge clk);
      ready[0] = 1'b1;
      wr_en[0] = 1'b1;
      din[0]   = 8'h55;
      @(negedge clk);
      ready[0] = 1'b0;
      wr_en[0] = 1'b0;
      check_eq("t4_xfer_valid", 64'(valid2[0]), 64'd0);
      check_eq("t4_xfer_busy", 64'(busy2[0]), 64'd1);
      check_eq("t4_xfer_ovf", 64'(eov2[0]), 64'd0);
      ready[0] = 1'b1;
      send_frame(0, 64'h55667788_12345678, 0, "t4b", 1);
      @(negedge clk);
      ready[0] = 1'b0;

      // Reset mid-frame, then flush mid-frame, then a clean frame
      for (int n = 0; n < 6; n++) send_byte(0, 8'hE0 + 8'(n));
      check_eq("t5_busy_pre", 64'(busy2[0]), 64'd1);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      check_eq("t5_rst_outs", {valid2[0], busy2[0], eto2[0], eov2[0], done2[0]}, 64'd0);
      check_eq("t5_rst_data", data2[0], 64'd0);
      for (int n = 0; n < 3; n++) send_byte(0, 8'hF0 + 8'(n));
      @(negedge clk);
      flush[0] = 1'b1;
      wr_en[0] = 1'b1;
      din[0]   = 8'hEE;
      @(negedge clk);
      flush[0] = 1'b0;
      wr_en[0] = 1'b0;
      check_eq("t5_flush_busy", 64'(busy2[0]), 64'd0);
      check_eq("t5_flush_done", 64'(done2[0]), 64'd0);
      check_eq("t5_flush_err", 64'({eto2[0], eov2[0]}), 64'd0);
      ready[0] = 1'b1;
      sb.push_back('{dut: 2'd0, data: 64'hC5C6C7C8_C1C2C3C4});
      send_frame(0, 64'hC1C2C3C4_C5C6C7C8, 0, "t5", 0);

      // Three 16-bit operands at one byte per cycle
      ready[3] = 1'b1;
      sb.push_back('{dut: 2'd3, data: 64'h0000_A5A6_A3A4_A1A2});
      for (int m = 0; m <= 6; m++) begin
         @(negedge clk);
         e3 = (m == 2) ? 3'b001 : (m == 4) ? 3'b010 : (m == 6) ? 3'b100 : 3'b000;
         check_eq("t6_done", 64'(done_d), 64'(e3));
         check_eq("t6_valid", 64'(valid_d), (m == 6) ? 64'd1 : 64'd0);
         if (m < 6) begin
            wr_en[3] = 1'b1;
            din[3]   = 8'(8'hA1 + m);
         end else begin
            wr_en[3] = 1'b0;
         end
      end

      repeat (4) @(negedge clk);
      check_eq("frames", 64'(n_frames), 64'd7);
      check_eq("sb_left", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
